// File: rtl/cook_sequencer.sv
// rtl/cook_sequencer.sv - microwave cook timer: BCD MM:SS entry, countdown and magnetron control
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   startn, stopn, clearn       active-low buttons (debounced, clk-synchronous)
//   door_closed                 high while the door is shut
//   key_valid, key_code[3:0]    one-cycle keypad strobe with BCD digit
//   mag_on                      magnetron enable, high exactly while cooking
//   timer_done                  one-cycle pulse on the first DONE cycle
//   min_tens..sec_ones[3:0]     BCD display MM:SS
//   state[1:0]                  IDLE=00 COOK=01 PAUSE=10 DONE=11
module cook_sequencer #(
  parameter int TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       startn,
  input  logic       stopn,
  input  logic       clearn,
  input  logic       door_closed,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       mag_on,
  output logic       timer_done,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_COOK  = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [3:0]    mt_q, mo_q, st_q, so_q;
  logic [3:0]    mt_d, mo_d, st_d, so_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          mag_on_q, timer_done_q, done_d;

  logic [3:0] dmt, dmo, dst, dso;
  logic       key_ok, time_nz, tick, dec_zero;

  assign key_ok   = key_valid && (key_code <= 4'd9);
  assign time_nz  = |{mt_q, mo_q, st_q, so_q};
  assign tick     = (presc_q == PMAX);
  assign dec_zero = ~|{dmt, dmo, dst, dso};

  // One-second BCD decrement with per-digit borrow. Seconds wrap to 59 when
  // borrowing from minutes; oversized entries like 01:90 simply count down.
  always_comb begin
    dmt = mt_q;
    dmo = mo_q;
    dst = st_q;
    dso = so_q;
    if (so_q != 4'd0) begin
      dso = so_q - 4'd1;
    end else begin
      dso = 4'd9;
      if (st_q != 4'd0) begin
        dst = st_q - 4'd1;
      end else begin
        dst = 4'd5;
        if (mo_q != 4'd0) begin
          dmo = mo_q - 4'd1;
        end else begin
          dmo = 4'd9;
          dmt = mt_q - 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (!clearn) begin
      state_d = S_IDLE;
      {mt_d, mo_d, st_d, so_d} = 16'h0000;
      presc_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!startn && door_closed && time_nz) begin
            state_d = S_COOK;
            presc_d = '0;
          end else if (key_ok) begin
            {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, key_code};
          end
        end
        S_COOK: begin
          // Stop / door-open beats a coinciding tick: time and prescaler hold.
          if (!stopn || !door_closed) begin
            state_d = S_PAUSE;
          end else if (tick) begin
            presc_d = '0;
            {mt_d, mo_d, st_d, so_d} = {dmt, dmo, dst, dso};
            if (dec_zero) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        S_PAUSE: begin
          if (!stopn) begin
            state_d = S_IDLE;
            {mt_d, mo_d, st_d, so_d} = 16'h0000;
            presc_d = '0;
          end else if (!startn && door_closed) begin
            state_d = S_COOK;
            presc_d = '0;
          end
        end
        default: begin
          if (!startn || !stopn) begin
            state_d = S_IDLE;
          end else if (key_ok) begin
            state_d = S_IDLE;
            {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, key_code};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      mt_q         <= 4'd0;
      mo_q         <= 4'd0;
      st_q         <= 4'd0;
      so_q         <= 4'd0;
      presc_q      <= '0;
      mag_on_q     <= 1'b0;
      timer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mt_q         <= mt_d;
      mo_q         <= mo_d;
      st_q         <= st_d;
      so_q         <= so_d;
      presc_q      <= presc_d;
      // Registered from the next state so it tracks state==COOK with no lag.
      mag_on_q     <= (state_d == S_COOK);
      timer_done_q <= done_d;
    end
  end

  assign mag_on     = mag_on_q;
  assign timer_done = timer_done_q;
  assign min_tens   = mt_q;
  assign min_ones   = mo_q;
  assign sec_tens   = st_q;
  assign sec_ones   = so_q;
  assign state      = state_q;

endmodule
